// File: rtl/alu_if.sv
// Operand/result bundle for the alu: two unsigned operands, an opcode, and the registered result.
// Latency: none (wires only); the result behind it appears one clock after the operands are sampled.
// Backpressure: none; the alu accepts a new operation on every clock edge.
//
// Signals:
//   portA, portB  IN_W-bit unsigned operands (driven by master)
//   opcode        2-bit operation select   (driven by master)
//   out           OUT_W-bit registered result/accumulator (driven by slave)
interface alu_if #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 16
);
    logic [IN_W-1:0]  portA;
    logic [IN_W-1:0]  portB;
    logic [1:0]       opcode;
    logic [OUT_W-1:0] out;

    modport master (
        output portA,
        output portB,
        output opcode,
        input  out
    );

    modport slave (
        input  portA,
        input  portB,
        input  opcode,
        output out
    );
endinterface

// File: rtl/alu.sv
// Registered ADD/MUL/MAC/SUB unit on two small unsigned operands with a 16-bit accumulator.
// Latency: 1 clock from operand sampling to out; a new operation every cycle.
// Backpressure: none; no handshake, every edge performs the selected operation.
//
// Ports:
//   clk   single clock, all updates on the rising edge
//   rst   synchronous active-high reset, clears out and wins over every opcode
//   bus   alu_if.slave: portA, portB, opcode in; out (registered) back
//
// Build option: define ALU_MAC_SAT_EN to make MAC saturate at all-ones instead
// of wrapping modulo 2^OUT_W. Other opcodes are identical either way.
module alu #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 16
) (
    input  logic   clk,
    input  logic   rst,
    alu_if.slave   bus
);
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MUL = 2'b01,
        OP_MAC = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    // Operands are widened first so every intermediate is OUT_W bits wide;
    // nothing is truncated before the final register write.
    logic [OUT_W-1:0] a_ext;
    logic [OUT_W-1:0] b_ext;
    logic [OUT_W-1:0] prod;
    logic [OUT_W-1:0] mac_res;
    logic [OUT_W-1:0] nxt;

    assign a_ext = OUT_W'(bus.portA);
    assign b_ext = OUT_W'(bus.portB);
    assign prod  = a_ext * b_ext;

`ifdef ALU_MAC_SAT_EN
    // One extra bit catches the carry out of the accumulate; clamp on carry.
    logic [OUT_W:0] mac_wide;
    assign mac_wide = {1'b0, bus.out} + {1'b0, prod};
    assign mac_res  = mac_wide[OUT_W] ? {OUT_W{1'b1}} : mac_wide[OUT_W-1:0];
`else
    // Plain OUT_W-bit add wraps modulo 2^OUT_W.
    assign mac_res = bus.out + prod;
`endif

    always_comb begin
        nxt = '0;
        case (op_e'(bus.opcode))
            OP_ADD:  nxt = a_ext + b_ext;
            OP_MUL:  nxt = prod;
            OP_MAC:  nxt = mac_res;
            // Subtracting zero-extended operands at full width already yields
            // the two's-complement sign extension of A-B (e.g. 2-5 -> 16'hFFFD).
            OP_SUB:  nxt = a_ext - b_ext;
            default: nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out <= '0;
        end else begin
            bus.out <= nxt;
        end
    end
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed sequences plus a randomized run against an arithmetic model.
// Latency: expects out to reflect the operation sampled at the previous rising edge.
// Backpressure: none exercised; the DUT accepts one operation per clock.
module tb_alu;
    localparam int IN_W  = 3;
    localparam int OUT_W = 16;

    logic clk = 1'b0;
    logic rst;

    alu_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bif ();

    alu #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int model      = 0;   // expected value of out after the latest edge

    // Reference: the value out must take after one edge, from the arithmetic rules.
    function automatic int ref_next(int cur, bit r, int a, int b, int op);
        int s;
        if (r) return 0;
        case (op)
            0: return a + b;
            1: return a * b;
            2: begin
                s = cur + a * b;
`ifdef ALU_MAC_SAT_EN
                if (s > 65535) s = 65535;
`else
                s = s % 65536;
`endif
                return s;
            end
            default: return (a - b) & 32'hFFFF;
        endcase
    endfunction

    task automatic check(input string tag, input int exp);
        compared++;
        assert (int'(bif.out) === exp)
        else begin
            mismatched++;
            $error("FAIL %s: out=%0d (0x%04h) expected %0d (0x%04h)",
                   tag, bif.out, bif.out, exp, exp[15:0]);
        end
    endtask

    // Drive one operation away from the edge, advance one edge, then compare to the model.
    task automatic do_op(input bit r, input int a, input int b, input int op, input string tag);
        @(negedge clk);
        rst        = r;
        bif.portA  = IN_W'(a);
        bif.portB  = IN_W'(b);
        bif.opcode = 2'(op);
        @(posedge clk);
        model = ref_next(model, r, a, b, op);
        #1;
        check(tag, model);
    endtask

    initial begin
        rst        = 1'b1;
        bif.portA  = '0;
        bif.portB  = '0;
        bif.opcode = '0;

        // Reset wins over a live MUL with nonzero operands.
        for (int i = 0; i < 10; i++) begin
            do_op(1'b1, 6, 6, 1, "reset");
            check("reset_zero", 0);
        end

        // Basic operations with literal expectations.
        do_op(1'b0, 6, 6, 0, "add");  check("add_6_6", 12);
        do_op(1'b0, 6, 6, 0, "add");  check("add_hold", 12);
        do_op(1'b0, 6, 6, 1, "mul");  check("mul_6_6", 36);
        do_op(1'b0, 2, 5, 3, "sub");  check("sub_2_5", 16'hFFFD);
        do_op(1'b0, 7, 7, 1, "mul");  check("mul_7_7", 49);
        do_op(1'b0, 7, 7, 0, "add");  check("add_7_7", 14);
        do_op(1'b0, 0, 7, 3, "sub");  check("sub_0_7", 16'hFFF9);

        // MAC from zero: 36*N after N edges.
        do_op(1'b1, 0, 0, 0, "mac_rst");
        for (int n = 1; n <= 1000; n++) begin
            do_op(1'b0, 6, 6, 2, "mac_run");
            if (n == 1) check("mac_1", 36);
            if (n == 2) check("mac_2", 72);
            if (n == 3) check("mac_3", 108);
        end
        check("mac_1000", 36000);

        // Continue to 65520 (= 36*1820), then one more MAC crosses 2^16.
        for (int n = 0; n < 820; n++) do_op(1'b0, 6, 6, 2, "mac_preload");
        check("mac_65520", 65520);
        do_op(1'b0, 6, 6, 2, "mac_edge");
`ifdef ALU_MAC_SAT_EN
        check("mac_sat", 16'hFFFF);
        do_op(1'b0, 6, 6, 2, "mac_sat_hold");
        check("mac_sat_hold", 16'hFFFF);
        do_op(1'b0, 1, 1, 2, "mac_sat_hold");
        check("mac_sat_hold2", 16'hFFFF);
`else
        check("mac_wrap", 20);
        do_op(1'b0, 6, 6, 2, "mac_after_wrap");
        check("mac_after_wrap", 56);
`endif

        // Reset in the middle of accumulation discards the sum.
        do_op(1'b1, 0, 0, 0, "mid_rst_pre");
        do_op(1'b0, 6, 6, 2, "mid_mac");
        do_op(1'b0, 6, 6, 2, "mid_mac");
        check("mid_72", 72);
        do_op(1'b1, 6, 6, 2, "mid_rst");
        check("mid_rst_zero", 0);
        do_op(1'b0, 6, 6, 2, "mid_resume");
        check("mid_resume_36", 36);

        // Switching away from MAC drops the accumulated value.
        do_op(1'b0, 6, 6, 2, "sw_mac");
        do_op(1'b0, 6, 6, 2, "sw_mac");
        check("sw_108", 108);
        do_op(1'b0, 6, 6, 1, "sw_mul");
        check("sw_mul_36", 36);

        // Randomized mix, occasional reset, long MAC runs to reach wrap/saturation.
        for (int i = 0; i < 2000; i++) begin
            int op;
            op = (($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 2);
            do_op(($urandom_range(0, 99) == 0), $urandom_range(0, 7),
                  $urandom_range(0, 7), op, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
